// File: rtl/microwave_panel.sv
// rtl/microwave_panel.sv - microwave front-panel controller (buttons/door to cook time, run request, beeper)
//
// Purpose: turns debounced operator buttons and the door sensor into the cook
// time tin and run request r for the range stage, watches the range stage's
// busy flag for completion and drives a fixed-length completion beep.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset
//   btn_add    in   add one time unit (level, debounced)
//   btn_start  in   start / resume (level, debounced)
//   btn_stop   in   stop / cancel (level, debounced)
//   door       in   door sensor, 1 = open
//   busy       in   running flag from the range stage
//   tin[3:0]   out  cook time presented to the range stage (registered)
//   r          out  run request (registered)
//   beep       out  completion beeper drive (registered)

module microwave_panel #(
    parameter int MAX_TIME = 15,
    parameter int BEEP_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_add,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       door,
    input  logic       busy,
    output logic [3:0] tin,
    output logic       r,
    output logic       beep
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] MAX_T     = 4'(MAX_TIME);
    // The fall-detect cycle is itself the first beep cycle, so load one less.
    localparam logic [7:0] BEEP_LOAD = 8'(BEEP_LEN - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [3:0] tin_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;

    logic add_q;
    logic start_q;
    logic stop_q;
    logic busy_q;

    logic add_ev;
    logic start_ev;
    logic stop_ev;
    logic busy_fall;

    // Edge registers start at 0, so a button held through reset release
    // yields one press event on the first clock.
    assign add_ev    = btn_add & ~add_q;
    assign start_ev  = btn_start & ~start_q;
    assign stop_ev   = btn_stop & ~stop_q;
    assign busy_fall = busy_q & ~busy;

    // Priority door > stop > busy-fall > start > add; each branch takes at most
    // one action. Door only has an action of its own in RUN; elsewhere it
    // merely blocks start.
    always_comb begin
        state_nx = state;
        tin_nx   = tin;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (add_ev) begin
                    state_nx = S_SET;
                    tin_nx   = 4'd1;
                end
            end
            S_SET, S_PAUSE: begin
                if (stop_ev) begin
                    state_nx = S_IDLE;
                    tin_nx   = 4'd0;
                end else if (start_ev && !door) begin
                    state_nx = S_RUN;
                end else if (add_ev) begin
                    tin_nx = (tin >= MAX_T) ? MAX_T : tin + 4'd1;
                end
            end
            S_RUN: begin
                // tin stays frozen here; add and start are ignored.
                if (door || stop_ev) begin
                    state_nx = S_PAUSE;
                end else if (busy_fall) begin
                    state_nx = S_DONE;
                    tin_nx   = 4'd0;
                    cnt_nx   = BEEP_LOAD;
                end
            end
            S_DONE: begin
                if (stop_ev || cnt == 8'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tin_nx   = 4'd0;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            tin     <= 4'd0;
            cnt     <= 8'd0;
            r       <= 1'b0;
            beep    <= 1'b0;
            add_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            tin     <= tin_nx;
            cnt     <= cnt_nx;
            r       <= (state_nx == S_RUN);
            beep    <= (state_nx == S_DONE);
            add_q   <= btn_add;
            start_q <= btn_start;
            stop_q  <= btn_stop;
            busy_q  <= busy;
        end
    end

endmodule

// File: tb/tb_microwave_panel.sv
// tb/tb_microwave_panel.sv - directed self-checking bench for microwave_panel

module tb_microwave_panel;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_add;
    logic       btn_start;
    logic       btn_stop;
    logic       door;
    logic       busy;
    logic [3:0] tin;
    logic       r;
    logic       beep;
    logic [3:0] tin9;
    logic       r9;
    logic       beep9;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    microwave_panel dut (
        .clk      (clk),
        .rst      (rst),
        .btn_add  (btn_add),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .door     (door),
        .busy     (busy),
        .tin      (tin),
        .r        (r),
        .beep     (beep)
    );

    microwave_panel #(.MAX_TIME(9), .BEEP_LEN(8)) dut9 (
        .clk      (clk),
        .rst      (rst),
        .btn_add  (btn_add),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .door     (door),
        .busy     (busy),
        .tin      (tin9),
        .r        (r9),
        .beep     (beep9)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_add();
        btn_add = 1'b1;
        tick();
        btn_add = 1'b0;
        tick();
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic press_stop();
        btn_stop = 1'b1;
        tick();
        btn_stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int nbeep;
        rst = 1'b0; btn_add = 0; btn_start = 0; btn_stop = 0; door = 0; busy = 0;
        repeat (3) tick();
        check("rst_tin", tin, 0);
        check("rst_r", r, 0);
        check("rst_beep", beep, 0);
        rst = 1'b1;
        tick();

        // Three adds: tin 1,2,3 one cycle after each press
        btn_add = 1; tick(); check("add1_tin", tin, 1); check("add1_r", r, 0);
        btn_add = 0; tick();
        btn_add = 1; tick(); check("add2_tin", tin, 2);
        btn_add = 0; tick();
        btn_add = 1; tick(); check("add3_tin", tin, 3); check("add3_r", r, 0);
        btn_add = 0; tick();
        // Held button gives no repeat
        btn_add = 1; tick(); btn_add = 1; tick(); tick();
        check("held_add_tin", tin, 4);
        btn_add = 0; tick();

        press_stop(); check("stop_tin", tin, 0); tick();

        // Saturation
        for (int i = 0; i < 20; i++) press_add();
        check("sat15_tin", tin, 15);
        check("sat9_tin", tin9, 9);
        press_stop(); tick();
        check("sat_clear_tin", tin, 0);

        // Door interlock
        for (int i = 0; i < 4; i++) press_add();
        check("tin4", tin, 4);
        door = 1;
        press_start(); check("door_start_r", r, 0);
        tick(); check("door_start_r2", r, 0);
        door = 0;
        press_start(); check("start_r", r, 1);
        tick();
        door = 1; tick();
        check("door_open_r", r, 0);
        check("door_open_tin", tin, 4);
        door = 0; tick();
        press_start(); check("resume_r", r, 1);
        check("resume_tin", tin, 4);

        // Completion and beep length
        busy = 1;
        repeat (10) tick();
        check("run_r", r, 1);
        busy = 0; tick();
        check("done_r", r, 0);
        check("done_tin", tin, 0);
        nbeep = 0;
        for (int i = 0; i < 20; i++) begin
            if (beep) nbeep++;
            tick();
        end
        check("beep_len", nbeep, 8);
        check("after_beep", beep, 0);
        press_start(); check("idle_start_r", r, 0);
        tick();

        // door + stop + busy-fall same cycle -> PAUSE, no beep
        press_add();
        press_start(); check("run2_r", r, 1);
        busy = 1; tick();
        door = 1; btn_stop = 1; busy = 0; tick();
        check("prio_r", r, 0);
        check("prio_beep", beep, 0);
        check("prio_tin", tin, 1);
        btn_stop = 0; door = 0; tick();
        check("prio_beep2", beep, 0);

        // Stop on third beep cycle
        press_start(); check("run3_r", r, 1);
        busy = 1; tick();
        busy = 0; tick();
        check("beep_c1", beep, 1);
        tick(); check("beep_c2", beep, 1);
        tick(); check("beep_c3", beep, 1);
        press_stop();
        check("stop_beep", beep, 0);
        check("stop_beep_tin", tin, 0);
        tick();
        press_start(); check("after_stop_idle_r", r, 0);
        tick();

        // Async reset mid-RUN
        press_add();
        press_start(); check("run4_r", r, 1);
        #2 rst = 0;
        #1;
        check("arst_run_r", r, 0);
        check("arst_run_tin", tin, 0);
        btn_start = 1;
        tick();
        rst = 1;
        tick(); check("rel_start_r", r, 0);
        tick(); check("rel_start_r2", r, 0);
        btn_start = 0; tick();

        // Async reset mid-DONE
        press_add();
        press_start();
        busy = 1; tick();
        busy = 0; tick();
        check("done5_beep", beep, 1);
        #2 rst = 0;
        #1;
        check("arst_done_beep", beep, 0);
        check("arst_done_tin", tin, 0);
        tick();
        rst = 1;
        tick();
        check("final_beep", beep, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_panel.md
# microwave_panel

Front-panel controller that sits directly upstream of the microwave range stage. It turns operator button presses and the door sensor into the cook-time value `tin[3:0]` and the run request `r`. It watches the range stage's running flag `busy` (that stage's `p` output) to detect cook completion and drives a completion beeper. All outputs are registered, and the block runs from a single clock.

## Interface
Parameters:
- `MAX_TIME`, default 15: saturation ceiling for `tin`; legal range 1..15.
- `BEEP_LEN`, default 8: number of cycles `beep` stays high after completion; legal range 1..255.

Ports:
- `clk`  input  1  sole clock, rising-edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `btn_add`  input  1  add-one-time-unit button; synchronous level, already debounced.
- `btn_start`  input  1  start/resume button; synchronous level, debounced.
- `btn_stop`  input  1  stop/cancel button; synchronous level, debounced.
- `door`  input  1  door sensor; 1 = open.
- `busy`  input  1  running flag from the range stage.
- `tin`  output  4  cook time presented to the range stage.
- `r`  output  1  run request to the range stage.
- `beep`  output  1  completion beeper drive.

## Operation
- Button edge detect:
  - One register per button; `*_q` resets to 0.
  - A press event is `btn & ~btn_q`, so exactly one event per low-to-high transition.
  - A button already high when reset releases counts as a press on the first clock.
- Busy fall detect: register `busy_q`, reset 0. A fall event is `busy_q & ~busy`.
- States:
  - IDLE: `tin` = 0, `r` = 0.
  - SET: `tin` > 0, `r` = 0.
  - RUN: `r` = 1.
  - PAUSE: `r` = 0, `tin` held.
  - DONE: `beep` = 1, `tin` = 0.
- Per-cycle priority, highest first: door > stop > busy-fall > start > add. At most one action is taken per cycle.
- Transitions:
  - IDLE + add → SET, `tin` = 1.
  - SET/PAUSE + add → `tin` = min(`tin` + 1, `MAX_TIME`); state unchanged. Saturates; no wrap.
  - SET/PAUSE + stop → IDLE, `tin` = 0.
  - SET/PAUSE + start with `door` = 0 → RUN. Start is ignored while `door` = 1.
  - RUN + `door` = 1 → PAUSE.
  - RUN + stop → PAUSE.
  - RUN + busy-fall → DONE, `tin` = 0, beep counter loaded with `BEEP_LEN` − 1.
  - RUN + add or start → ignored; `tin` stays frozen while `r` = 1.
  - DONE + stop → IDLE, `beep` = 0 immediately next cycle.
  - DONE with counter = 0 → IDLE. Otherwise the counter decrements by 1.
  - IDLE + start/stop → ignored. DONE + add/start → ignored.
- PAUSE does not restore the range stage's remaining count. Resume re-asserts `r` with the held `tin`; the range stage owns the countdown.
- Busy-fall outside RUN has no effect.
- Encoding: 3-bit state; values 5..7 are illegal and recover to IDLE on the next clock with `tin` = 0.
- Beep counter: 8 bits, unsigned. It is only meaningful in DONE.

## Timing
- Reset (`rst` = 0, asynchronous): state IDLE, `tin` = 0, `r` = 0, `beep` = 0, all edge registers 0, beep counter 0. Takes effect immediately, including mid-RUN or mid-DONE.
- Latency from a sampled input event to an output change is 1 cycle. Example: `btn_start` high at rising edge n (low at n−1) → `r` = 1 after edge n.
- Door open during RUN → `r` low after the same edge that samples `door` = 1.
- `beep` is high for exactly `BEEP_LEN` consecutive cycles, starting the cycle after busy-fall. Stop truncates it.
- A held button produces no repeat events. A release followed by a re-press is required.

## Test plan
- Reset, then 3 `btn_add` pulses → `tin` 1, 2, 3, each one cycle after its press; state SET; `r` = 0 throughout.
- 20 add pulses from IDLE → `tin` saturates at 15 and stays 15. With `MAX_TIME` = 9, it saturates at 9.
- `tin` = 4, start with `door` = 1 → `r` stays 0. Drop `door`, press start → `r` = 1 next cycle. Raise `door` → `r` = 0 next cycle, `tin` = 4. Close door, press start → `r` = 1.
- In RUN, drive `busy` 1 for 10 cycles, then 0 → `r` = 0, `tin` = 0, `beep` high for exactly 8 cycles, then IDLE.
- Same cycle: `door` = 1, stop pressed, and busy falling in RUN → PAUSE wins, no beep. During DONE, press stop on the 3rd beep cycle → `beep` = 0 next cycle, state IDLE.
- Pull `rst` low asynchronously mid-RUN and mid-DONE → `r`, `beep`, `tin` = 0 without waiting for a clock. Press `btn_start` before releasing reset, then release → press counted but ignored in IDLE; `r` stays 0.
